util_fifo_axis_burst: RTL and testbench

- Downstream drain stage for util_stepup_fifo. It reads 64-bit words from the FIFO's rden/empty/dcnt/dout interface.
- Emits the words as an AXI4-Stream master in fixed-length bursts, with tlast on every BURST_LEN-th beat, for the PS DMA (S2MM).
- A flush request emits any residual partial burst so the tail of a transfer is not stranded in the FIFO.

---
 rtl/util_fifo_axis_burst_pkg.sv | 13 +
 rtl/util_fifo_axis_burst_skid.sv | 57 +++++
 rtl/util_fifo_axis_burst.sv | 126 ++++++++++++
 tb/tb_util_fifo_axis_burst.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/util_fifo_axis_burst_pkg.sv
// Shared types and constants for the FIFO-to-AXI-Stream burst drain stage.
package util_fifo_axis_burst_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StBurst
  } burst_state_e;

  // Two entries cover the one-cycle FIFO read latency plus one stalled beat.
  localparam int unsigned SkidDepth = 2;
  localparam int unsigned SkidCntW  = $clog2(SkidDepth + 1);

endpackage

// File: rtl/util_fifo_axis_burst_skid.sv
// Small registered skid buffer: absorbs FIFO read data while the stream is stalled.
module util_fifo_axis_burst_skid
  import util_fifo_axis_burst_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [DATA_W-1:0]   din_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [DATA_W-1:0]   dout_o,
  output logic [SkidCntW-1:0] count_o
);

  logic [DATA_W-1:0]   mem_q [SkidDepth];
  logic [DATA_W-1:0]   mem_d [SkidDepth];
  logic [SkidCntW-1:0] count_q, count_d;
  logic [SkidCntW-1:0] base;
  logic                pop;

  assign valid_o = (count_q != '0);
  assign pop     = valid_o && ready_i;
  assign dout_o  = mem_q[0];
  assign count_o = count_q;

  always_comb begin
    mem_d   = mem_q;
    base    = count_q - SkidCntW'(pop);
    if (pop) begin
      for (int i = 0; i < SkidDepth - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
    end
    // The write slot is the occupancy left after this cycle's pop.
    for (int i = 0; i < SkidDepth; i++) begin
      if (push_i && (base == SkidCntW'(i))) begin
        mem_d[i] = din_i;
      end
    end
    count_d = base + SkidCntW'(push_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < SkidDepth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/util_fifo_axis_burst.sv
// Drains util_stepup_fifo into an AXI4-Stream master as fixed-length bursts,
// with a flush request that emits any residual partial burst.
module util_fifo_axis_burst
  import util_fifo_axis_burst_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned DCNT_W    = 32,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned BCNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fifo_rden,
  input  logic              fifo_empty,
  input  logic [DCNT_W-1:0] fifo_dcnt,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic [BCNT_W-1:0] burst_cnt
);

  burst_state_e        state_q, state_d;
  logic [BCNT_W-1:0]   rd_rem_q, rd_rem_d;
  logic [BCNT_W-1:0]   out_rem_q, out_rem_d;
  logic [BCNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic                flush_q, flush_d;
  logic                rd_pending_q;
  logic [SkidCntW-1:0] skid_cnt;
  logic [SkidCntW:0]   occ;
  logic                pop;
  logic                full_avail;

  util_fifo_axis_burst_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rd_pending_q),
    .din_i   (fifo_dout),
    .valid_o (m_axis_tvalid),
    .ready_i (m_axis_tready),
    .dout_o  (m_axis_tdata),
    .count_o (skid_cnt)
  );

  assign pop        = m_axis_tvalid && m_axis_tready;
  assign full_avail = (fifo_dcnt >= DCNT_W'(BURST_LEN));

  // Words held or in flight once this cycle's pop retires; keeps the skid from overflowing.
  assign occ = {1'b0, skid_cnt} + {{SkidCntW{1'b0}}, rd_pending_q}
             - {{SkidCntW{1'b0}}, pop};

  always_comb begin
    state_d     = state_q;
    rd_rem_d    = rd_rem_q;
    out_rem_d   = out_rem_q;
    burst_cnt_d = burst_cnt_q;
    flush_d     = flush_q;
    fifo_rden   = 1'b0;
    flush_done  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (full_avail) begin
          rd_rem_d  = BCNT_W'(BURST_LEN);
          out_rem_d = BCNT_W'(BURST_LEN);
          flush_d   = 1'b0;
          state_d   = StBurst;
        end else if (flush_req && (fifo_dcnt != '0)) begin
          // Below BURST_LEN here, so the truncating cast is lossless.
          rd_rem_d  = BCNT_W'(fifo_dcnt);
          out_rem_d = BCNT_W'(fifo_dcnt);
          flush_d   = 1'b1;
          state_d   = StBurst;
        end else if (flush_req) begin
          flush_done = 1'b1;
        end
      end
      StBurst: begin
        fifo_rden = (rd_rem_q != '0) && !fifo_empty
                 && (occ < (SkidCntW + 1)'(SkidDepth));
        if (fifo_rden) begin
          rd_rem_d = rd_rem_q - BCNT_W'(1);
        end
        if (pop) begin
          out_rem_d = out_rem_q - BCNT_W'(1);
          if (out_rem_q == BCNT_W'(1)) begin
            state_d     = StIdle;
            burst_cnt_d = burst_cnt_q + BCNT_W'(1);
            flush_done  = flush_q;
            flush_d     = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rd_rem_q     <= '0;
      out_rem_q    <= '0;
      burst_cnt_q  <= '0;
      flush_q      <= 1'b0;
      rd_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_rem_q     <= rd_rem_d;
      out_rem_q    <= out_rem_d;
      burst_cnt_q  <= burst_cnt_d;
      flush_q      <= flush_d;
      rd_pending_q <= fifo_rden;
    end
  end

  assign m_axis_tlast = m_axis_tvalid && (state_q == StBurst) && (out_rem_q == BCNT_W'(1));
  assign busy         = (state_q != StIdle);
  assign burst_cnt    = burst_cnt_q;

endmodule

// File: tb/tb_util_fifo_axis_burst.sv
// Scoreboard bench for util_fifo_axis_burst with a behavioural FIFO model.
module tb_util_fifo_axis_burst;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned DCNT_W    = 32;
  localparam int unsigned BURST_LEN = 16;
  localparam int unsigned BCNT_W    = 16;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fifo_rden;
  logic              fifo_empty = 1'b1;
  logic [DCNT_W-1:0] fifo_dcnt  = '0;
  logic [DATA_W-1:0] fifo_dout  = '0;
  logic              flush_req  = 1'b0;
  logic              flush_done;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tlast;
  logic              busy;
  logic [BCNT_W-1:0] burst_cnt;

  always #5 clk = ~clk;

  util_fifo_axis_burst #(
    .DATA_W    (DATA_W),
    .DCNT_W    (DCNT_W),
    .BURST_LEN (BURST_LEN),
    .BCNT_W    (BCNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_rden     (fifo_rden),
    .fifo_empty    (fifo_empty),
    .fifo_dcnt     (fifo_dcnt),
    .fifo_dout     (fifo_dout),
    .flush_req     (flush_req),
    .flush_done    (flush_done),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .burst_cnt     (burst_cnt)
  );

  logic [63:0] fq[$];
  logic [63:0] push_q[$];
  beat_t       exp_q[$];
  int          hs_cyc[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          hs_cnt   = 0;
  int          last_cnt = 0;
  int          fd_cnt   = 0;
  logic        stall_q  = 1'b0;
  logic [63:0] stall_data = '0;
  logic        stall_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model: one-cycle read latency; pushes become visible at the next edge.
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      push_q.delete();
      fifo_dcnt  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rden && fq.size() > 0) fifo_dout <= fq.pop_front();
      while (push_q.size() > 0) fq.push_back(push_q.pop_front());
      fifo_dcnt  <= DCNT_W'(fq.size());
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Stream monitor, sampled mid-cycle.
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (fifo_rden) check("rden_while_empty", 64'(fifo_empty), 64'(0));
      if (stall_q) begin
        check("hold_tvalid", 64'(m_axis_tvalid), 64'(1));
        check("hold_tdata", m_axis_tdata, stall_data);
        check("hold_tlast", 64'(m_axis_tlast), 64'(stall_last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        hs_cnt++;
        hs_cyc.push_back(cyc);
        if (m_axis_tlast) last_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", m_axis_tdata, 64'hdead_beef);
        end else begin
          e = exp_q.pop_front();
          check("tdata", m_axis_tdata, e.data);
          check("tlast", 64'(m_axis_tlast), 64'(e.last));
        end
      end
      stall_q    = m_axis_tvalid && !m_axis_tready;
      stall_data = m_axis_tdata;
      stall_last = m_axis_tlast;
      if (flush_done) begin
        fd_cnt++;
        if (m_axis_tvalid) begin
          check("flush_done_on_tlast", 64'(m_axis_tready && m_axis_tlast), 64'(1));
          check("flush_done_drained", 64'(exp_q.size()), 64'(0));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) push_q.push_back(64'(base + i));
    tick();
  endtask

  task automatic expect_seq(input int base, input int n, input int blen);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = 64'(base + i);
      b.last = ((i % blen) == blen - 1) || (i == n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_done(input int max, input bit drop, input bit tog);
    int fd0;
    bit done;
    fd0  = fd_cnt;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      tick();
      if (tog) m_axis_tready = ~m_axis_tready;
      if (drop && fd_cnt != fd0) flush_req = 1'b0;
      if (exp_q.size() == 0 && !busy && !flush_req) done = 1'b1;
    end
    m_axis_tready = 1'b1;
    check("wait_done", 64'(done), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, l0, f0, b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_rden", 64'(fifo_rden), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_tlast", 64'(m_axis_tlast), 64'(0));
    check("rst_flush_done", 64'(flush_done), 64'(0));
    check("rst_burst_cnt", 64'(burst_cnt), 64'(0));
    tick();
    rst = 1'b0;

    // Two full bursts at full rate.
    h0 = hs_cyc.size();
    l0 = last_cnt;
    expect_seq(0, 32, BURST_LEN);
    load(0, 32);
    wait_done(400, 1'b0, 1'b0);
    check("t1_burst_cnt", 64'(burst_cnt), 64'(2));
    check("t1_tlasts", 64'(last_cnt - l0), 64'(2));
    check("t1_b2b_first", 64'(hs_cyc[h0+15] - hs_cyc[h0]), 64'(15));
    check("t1_b2b_second", 64'(hs_cyc[h0+31] - hs_cyc[h0+16]), 64'(15));

    // Backpressure: tready toggling.
    b0 = hs_cnt;
    l0 = last_cnt;
    expect_seq(100, 16, BURST_LEN);
    load(100, 16);
    wait_done(400, 1'b0, 1'b1);
    check("t2_handshakes", 64'(hs_cnt - b0), 64'(16));
    check("t2_tlasts", 64'(last_cnt - l0), 64'(1));
    check("t2_burst_cnt", 64'(burst_cnt), 64'(3));

    // Partial flush of 5 words.
    f0 = fd_cnt;
    expect_seq(200, 5, BURST_LEN);
    load(200, 5);
    flush_req = 1'b1;
    wait_done(200, 1'b1, 1'b0);
    check("t3_flush_done_cnt", 64'(fd_cnt - f0), 64'(1));
    check("t3_burst_cnt", 64'(burst_cnt), 64'(4));
    check("t3_busy", 64'(busy), 64'(0));

    // Flush with an empty FIFO.
    f0 = fd_cnt;
    flush_req = 1'b1;
    @(negedge clk);
    check("t4_flush_done", 64'(flush_done), 64'(1));
    check("t4_tvalid", 64'(m_axis_tvalid), 64'(0));
    tick();
    flush_req = 1'b0;
    @(negedge clk);
    check("t4_busy", 64'(busy), 64'(0));
    check("t4_tvalid_after", 64'(m_axis_tvalid), 64'(0));
    tick();
    check("t4_flush_done_cnt", 64'(fd_cnt - f0), 64'(1));
    check("t4_burst_cnt", 64'(burst_cnt), 64'(4));

    // 20 words with flush: full burst first, then a 4-beat tail.
    f0 = fd_cnt;
    l0 = last_cnt;
    expect_seq(500, 20, BURST_LEN);
    load(500, 20);
    flush_req = 1'b1;
    wait_done(600, 1'b1, 1'b0);
    check("t5_flush_done_cnt", 64'(fd_cnt - f0), 64'(1));
    check("t5_tlasts", 64'(last_cnt - l0), 64'(2));
    check("t5_burst_cnt", 64'(burst_cnt), 64'(6));

    // Reset mid-burst after beat 7, then a fresh burst.
    b0 = hs_cnt;
    expect_seq(300, 16, BURST_LEN);
    load(300, 16);
    for (int i = 0; i < 200 && (hs_cnt - b0) < 7; i++) tick();
    check("t6_beat7_reached", 64'(hs_cnt - b0), 64'(7));
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("t6_rden", 64'(fifo_rden), 64'(0));
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_burst_cnt", 64'(burst_cnt), 64'(0));
    tick();
    expect_seq(400, 16, BURST_LEN);
    load(400, 16);
    wait_done(400, 1'b0, 1'b0);
    check("t6_burst_cnt_after", 64'(burst_cnt), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
